// File: rtl/cheri_cap_pkg.sv
// Purpose: shared capability-image word layout, load fault codes and sequencer states.
// Latency: none, declarations only.
// Backpressure: none.
package cheri_cap_pkg;

    // Word index of each field inside the 12-word capability image.
    localparam logic [3:0] CAP_W_BASE_LO  = 4'd0;
    localparam logic [3:0] CAP_W_BASE_HI  = 4'd1;
    localparam logic [3:0] CAP_W_LEN_LO   = 4'd2;
    localparam logic [3:0] CAP_W_LEN_HI   = 4'd3;
    localparam logic [3:0] CAP_W_CUR_LO   = 4'd4;
    localparam logic [3:0] CAP_W_CUR_HI   = 4'd5;
    localparam logic [3:0] CAP_W_PERMS    = 4'd6;
    localparam logic [3:0] CAP_W_PERMS_HI = 4'd7;
    localparam logic [3:0] CAP_W_ATTR     = 4'd8;
    localparam logic [3:0] CAP_W_ATTR_HI  = 4'd9;
    localparam logic [3:0] CAP_W_TAG      = 4'd10;
    localparam logic [3:0] CAP_W_TAG_HI   = 4'd11;
    localparam logic [3:0] CAP_WORDS      = 4'd12;

    typedef enum logic [2:0] {
        CLD_F_NONE = 3'd0,
        CLD_F_TAG  = 3'd1,
        CLD_F_PERM = 3'd2,
        CLD_F_LO   = 3'd3,
        CLD_F_HI   = 3'd4,
        CLD_F_MALF = 3'd5
    } cld_fault_e;

    typedef enum logic [2:0] {
        CLD_IDLE  = 3'd0,
        CLD_CHECK = 3'd1,
        CLD_ISSUE = 3'd2,
        CLD_WAIT  = 3'd3,
        CLD_WB    = 3'd4,
        CLD_FAULT = 3'd5,
        CLD_DRAIN = 3'd6
    } cld_state_e;

endpackage

// File: rtl/cheri_bounds_chk.sv
// Purpose: tag / permission / bounds check of an access through an authorising capability.
// Latency: combinational.
// Backpressure: none.
// Ports: tag, perms, base, len -> authorising CR; addr -> first word of access;
//        code -> first failing check in priority order tag, perm, low bound, high bound.
module cheri_bounds_chk
    import cheri_cap_pkg::*;
#(
    parameter int ADDR_W       = 48,
    parameter int PERM_BIT     = 3,
    parameter int ACCESS_WORDS = 12
) (
    input  logic              tag,
    input  logic [23:0]       perms,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    input  logic [ADDR_W-1:0] addr,
    output cld_fault_e        code
);

    // One extra bit so neither the limit nor the access end can wrap.
    logic [ADDR_W:0] limit;
    logic [ADDR_W:0] acc_end;

    always_comb begin
        limit   = {1'b0, base} + {1'b0, len};
        acc_end = {1'b0, addr} + (ADDR_W+1)'(ACCESS_WORDS);
        code    = CLD_F_NONE;
        if (!tag)
            code = CLD_F_TAG;
        else if (!perms[PERM_BIT])
            code = CLD_F_PERM;
        else if (addr < base)
            code = CLD_F_LO;
        else if (acc_end > limit)
            code = CLD_F_HI;
    end

endmodule

// File: rtl/cheri_cld_seq.sv
// Purpose: capability-load sequencer: check, read 12 image words, reassemble, write back.
// Latency: 26 cycles start->ow_wb_valid with 1-cycle grant and 1-cycle rvalid; faults pulse 2 cycles after start.
// Backpressure: ow_mem_req/addr hold until iw_mem_gnt; result held in WB until iw_wb_ready.
// Ports: iw_start/iw_auth_*/iw_imm request; ow_mem_*/iw_mem_* single-outstanding read port;
//        ow_wb_valid/iw_wb_ready + ow_cap_* result; ow_fault/ow_fault_code cause pulse; ow_busy.
// Build option: CHERI_CLD_STRICT_EN turns a malformed image into fault code 5 instead of a cleared tag.
module cheri_cld_seq
    import cheri_cap_pkg::*;
#(
    parameter int ADDR_W = 48,
    parameter int DATA_W = 24,
    parameter int LC_BIT = 3,
    parameter int LT_BIT = 4
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic              iw_start,
    input  logic [ADDR_W-1:0] iw_auth_base,
    input  logic [ADDR_W-1:0] iw_auth_len,
    input  logic [ADDR_W-1:0] iw_auth_cur,
    input  logic [23:0]       iw_auth_perms,
    input  logic              iw_auth_tag,
    input  logic [9:0]        iw_imm,
    input  logic              iw_flush,
    output logic              ow_mem_req,
    output logic [ADDR_W-1:0] ow_mem_addr,
    input  logic              iw_mem_gnt,
    input  logic              iw_mem_rvalid,
    input  logic [DATA_W-1:0] iw_mem_rdata,
    output logic              ow_wb_valid,
    input  logic              iw_wb_ready,
    output logic [ADDR_W-1:0] ow_cap_base,
    output logic [ADDR_W-1:0] ow_cap_len,
    output logic [ADDR_W-1:0] ow_cap_cur,
    output logic [23:0]       ow_cap_perms,
    output logic [23:0]       ow_cap_attr,
    output logic              ow_cap_tag,
    output logic              ow_fault,
    output logic [2:0]        ow_fault_code,
    output logic              ow_busy
);

`ifdef CHERI_CLD_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    cld_state_e        state;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] auth_base_q, auth_len_q, auth_cur_q, eff_q;
    logic [23:0]       auth_perms_q;
    logic              auth_tag_q;
    logic [9:0]        imm_q;
    logic              tag_bit_q;
    logic              malf_q;
    logic              malf_word;
    logic              malf_now;
    logic [ADDR_W-1:0] eff;
    cld_fault_e        chk_code;

    assign eff      = auth_cur_q + {{(ADDR_W-10){imm_q[9]}}, imm_q};
    assign malf_now = malf_q | malf_word;

    cheri_bounds_chk #(
        .ADDR_W       (ADDR_W),
        .PERM_BIT     (LC_BIT),
        .ACCESS_WORDS (int'(CAP_WORDS))
    ) u_chk (
        .tag   (auth_tag_q),
        .perms (auth_perms_q),
        .base  (auth_base_q),
        .len   (auth_len_q),
        .addr  (eff),
        .code  (chk_code)
    );

    // Padding words and the upper bits of the tag word must read as zero.
    always_comb begin
        malf_word = 1'b0;
        case (cnt_q)
            CAP_W_PERMS_HI, CAP_W_ATTR_HI, CAP_W_TAG_HI: malf_word = |iw_mem_rdata;
            CAP_W_TAG:                                   malf_word = |iw_mem_rdata[DATA_W-1:1];
            default:                                     malf_word = 1'b0;
        endcase
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state         <= CLD_IDLE;
            cnt_q         <= 4'd0;
            auth_base_q   <= '0;
            auth_len_q    <= '0;
            auth_cur_q    <= '0;
            auth_perms_q  <= '0;
            auth_tag_q    <= 1'b0;
            imm_q         <= '0;
            eff_q         <= '0;
            tag_bit_q     <= 1'b0;
            malf_q        <= 1'b0;
            ow_mem_req    <= 1'b0;
            ow_mem_addr   <= '0;
            ow_wb_valid   <= 1'b0;
            ow_cap_base   <= '0;
            ow_cap_len    <= '0;
            ow_cap_cur    <= '0;
            ow_cap_perms  <= '0;
            ow_cap_attr   <= '0;
            ow_cap_tag    <= 1'b0;
            ow_fault      <= 1'b0;
            ow_fault_code <= '0;
            ow_busy       <= 1'b0;
        end else begin
            ow_fault <= 1'b0;
            case (state)
                CLD_IDLE: begin
                    if (iw_start) begin
                        auth_base_q  <= iw_auth_base;
                        auth_len_q   <= iw_auth_len;
                        auth_cur_q   <= iw_auth_cur;
                        auth_perms_q <= iw_auth_perms;
                        auth_tag_q   <= iw_auth_tag;
                        imm_q        <= iw_imm;
                        ow_busy      <= 1'b1;
                        state        <= CLD_CHECK;
                    end
                end
                CLD_CHECK: begin
                    if (iw_flush) begin
                        ow_busy <= 1'b0;
                        state   <= CLD_IDLE;
                    end else if (chk_code != CLD_F_NONE) begin
                        ow_fault      <= 1'b1;
                        ow_fault_code <= chk_code;
                        state         <= CLD_FAULT;
                    end else begin
                        eff_q        <= eff;
                        cnt_q        <= 4'd0;
                        malf_q       <= 1'b0;
                        tag_bit_q    <= 1'b0;
                        ow_cap_base  <= '0;
                        ow_cap_len   <= '0;
                        ow_cap_cur   <= '0;
                        ow_cap_perms <= '0;
                        ow_cap_attr  <= '0;
                        ow_cap_tag   <= 1'b0;
                        ow_mem_req   <= 1'b1;
                        ow_mem_addr  <= eff;
                        state        <= CLD_ISSUE;
                    end
                end
                CLD_ISSUE: begin
                    // A grant in the flush cycle still leaves a response in flight.
                    if (iw_mem_gnt) begin
                        ow_mem_req <= 1'b0;
                        state      <= iw_flush ? CLD_DRAIN : CLD_WAIT;
                    end else if (iw_flush) begin
                        ow_mem_req <= 1'b0;
                        ow_busy    <= 1'b0;
                        state      <= CLD_IDLE;
                    end
                end
                CLD_WAIT: begin
                    if (iw_flush) begin
                        // A response arriving with the flush is simply dropped.
                        ow_busy <= ~iw_mem_rvalid;
                        state   <= iw_mem_rvalid ? CLD_IDLE : CLD_DRAIN;
                    end else if (iw_mem_rvalid) begin
                        malf_q <= malf_now;
                        case (cnt_q)
                            CAP_W_BASE_LO: ow_cap_base[DATA_W-1:0]      <= iw_mem_rdata;
                            CAP_W_BASE_HI: ow_cap_base[ADDR_W-1:DATA_W] <= iw_mem_rdata[ADDR_W-DATA_W-1:0];
                            CAP_W_LEN_LO:  ow_cap_len[DATA_W-1:0]       <= iw_mem_rdata;
                            CAP_W_LEN_HI:  ow_cap_len[ADDR_W-1:DATA_W]  <= iw_mem_rdata[ADDR_W-DATA_W-1:0];
                            CAP_W_CUR_LO:  ow_cap_cur[DATA_W-1:0]       <= iw_mem_rdata;
                            CAP_W_CUR_HI:  ow_cap_cur[ADDR_W-1:DATA_W]  <= iw_mem_rdata[ADDR_W-DATA_W-1:0];
                            CAP_W_PERMS:   ow_cap_perms                 <= iw_mem_rdata[23:0];
                            CAP_W_ATTR:    ow_cap_attr                  <= iw_mem_rdata[23:0];
                            CAP_W_TAG:     tag_bit_q                    <= iw_mem_rdata[0];
                            default: ;
                        endcase
                        if (cnt_q == CAP_W_TAG_HI) begin
                            if (STRICT && malf_now) begin
                                ow_fault      <= 1'b1;
                                ow_fault_code <= CLD_F_MALF;
                                state         <= CLD_FAULT;
                            end else begin
                                ow_cap_tag  <= tag_bit_q & ~malf_now & auth_perms_q[LT_BIT];
                                ow_wb_valid <= 1'b1;
                                state       <= CLD_WB;
                            end
                        end else begin
                            cnt_q       <= cnt_q + 4'd1;
                            ow_mem_req  <= 1'b1;
                            ow_mem_addr <= eff_q + {{(ADDR_W-4){1'b0}}, cnt_q + 4'd1};
                            state       <= CLD_ISSUE;
                        end
                    end
                end
                CLD_WB: begin
                    if (iw_wb_ready || iw_flush) begin
                        ow_wb_valid <= 1'b0;
                        ow_busy     <= 1'b0;
                        state       <= CLD_IDLE;
                    end
                end
                CLD_FAULT: begin
                    ow_fault_code <= '0;
                    ow_busy       <= 1'b0;
                    state         <= CLD_IDLE;
                end
                CLD_DRAIN: begin
                    if (iw_mem_rvalid) begin
                        ow_busy <= 1'b0;
                        state   <= CLD_IDLE;
                    end
                end
                default: begin
                    ow_busy <= 1'b0;
                    state   <= CLD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cheri_cld_seq.sv
// Purpose: self-checking bench for cheri_cld_seq with a behavioural memory and result model.
// Latency: n/a.
// Backpressure: memory grant stall, response delay and writeback ready delay are programmable.
module tb_cheri_cld_seq;

`ifdef CHERI_CLD_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [47:0] auth_base = '0, auth_len = '0, auth_cur = '0;
    logic [23:0] auth_perms = '0;
    logic        auth_tag = 1'b0;
    logic [9:0]  imm = '0;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [47:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [23:0] mem_rdata = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [47:0] cap_base, cap_len, cap_cur;
    logic [23:0] cap_perms, cap_attr;
    logic        cap_tag;
    logic        fault;
    logic [2:0]  fault_code;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    cheri_cld_seq dut (
        .iw_clk(clk), .iw_rst_n(rst_n), .iw_start(start),
        .iw_auth_base(auth_base), .iw_auth_len(auth_len), .iw_auth_cur(auth_cur),
        .iw_auth_perms(auth_perms), .iw_auth_tag(auth_tag), .iw_imm(imm), .iw_flush(flush),
        .ow_mem_req(mem_req), .ow_mem_addr(mem_addr), .iw_mem_gnt(mem_gnt),
        .iw_mem_rvalid(mem_rvalid), .iw_mem_rdata(mem_rdata),
        .ow_wb_valid(wb_valid), .iw_wb_ready(wb_ready),
        .ow_cap_base(cap_base), .ow_cap_len(cap_len), .ow_cap_cur(cap_cur),
        .ow_cap_perms(cap_perms), .ow_cap_attr(cap_attr), .ow_cap_tag(cap_tag),
        .ow_fault(fault), .ow_fault_code(fault_code), .ow_busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- memory responder (drives on the falling edge) ----------------
    logic [23:0] mem [0:1023];
    int          stall_n = 0, rlat = 1;
    int          st_cnt = 0, pend_cnt = 0;
    bit          pend = 0, hold_act = 0;
    logic [47:0] pend_addr = '0, gnt_addr = '0, hold_addr = '0;
    int          n_req_cyc = 0, n_gnt = 0, proto_viol = 0;
    logic [47:0] gnt_q [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; pend = 0; st_cnt = 0; hold_act = 0;
        end else begin
            mem_rvalid = 1'b0;
            if (mem_gnt) begin
                pend = 1; pend_cnt = rlat; pend_addr = gnt_addr;
            end
            if (pend) begin
                pend_cnt--;
                if (pend_cnt <= 0) begin
                    mem_rvalid = 1'b1; mem_rdata = mem[pend_addr[9:0]]; pend = 0;
                end
            end
            mem_gnt = 1'b0;
            if (mem_req) begin
                n_req_cyc++;
                if (pend) proto_viol++;
                if (hold_act && mem_addr !== hold_addr) proto_viol++;
                hold_act = 1; hold_addr = mem_addr;
                if (st_cnt >= stall_n) begin
                    mem_gnt = 1'b1; gnt_addr = mem_addr; gnt_q.push_back(mem_addr);
                    n_gnt++; st_cnt = 0; hold_act = 0;
                end else begin
                    st_cnt++;
                end
            end else begin
                hold_act = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model(output logic [2:0] code, output logic [47:0] eb, el, ec,
                         output logic [23:0] ep, ea, output logic et);
        logic [47:0] e;
        logic [48:0] lim, top;
        int a;
        bit malf;
        e   = auth_cur + {{38{imm[9]}}, imm};
        lim = {1'b0, auth_base} + {1'b0, auth_len};
        top = {1'b0, e} + 49'd12;
        if (!auth_tag)          code = 3'd1;
        else if (!auth_perms[3]) code = 3'd2;
        else if (e < auth_base) code = 3'd3;
        else if (top > lim)     code = 3'd4;
        else                    code = 3'd0;
        eb = '0; el = '0; ec = '0; ep = '0; ea = '0; et = 1'b0;
        if (code == 3'd0) begin
            a    = int'(e[9:0]);
            eb   = {mem[a+1], mem[a]};
            el   = {mem[a+3], mem[a+2]};
            ec   = {mem[a+5], mem[a+4]};
            ep   = mem[a+6];
            ea   = mem[a+8];
            malf = (mem[a+7] != 0) || (mem[a+9] != 0) || (mem[a+11] != 0) || (mem[a+10][23:1] != 0);
            et   = mem[a+10][0] & ~malf & auth_perms[4];
            if (STRICT && malf) code = 3'd5;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_auth(input int b, input int l, input int c, input logic [23:0] p,
                            input logic t, input int im);
        auth_base = 48'(b); auth_len = 48'(l); auth_cur = 48'(c);
        auth_perms = p; auth_tag = t; imm = 10'(im);
    endtask

    task automatic std_image(input int a, input logic [23:0] w11);
        mem[a+0] = 24'h0004D2; mem[a+1] = 24'h0; mem[a+2] = 24'h00162E; mem[a+3] = 24'h0;
        mem[a+4] = 24'h016383; mem[a+5] = 24'h0; mem[a+6] = 24'h00ABCD; mem[a+7] = 24'h0;
        mem[a+8] = 24'h001122; mem[a+9] = 24'h0; mem[a+10] = 24'h000001; mem[a+11] = w11;
    endtask

    task automatic rand_image(input int a, input bit malf);
        for (int k = 0; k < 12; k++) mem[a+k] = 24'h0;
        for (int k = 0; k < 7; k++) mem[a+k] = 24'($urandom);
        mem[a+8]  = 24'($urandom);
        mem[a+10] = {23'h0, 1'($urandom)};
        if (malf) begin
            case ($urandom_range(0, 3))
                0: mem[a+7]  = 24'($urandom_range(1, 24'hFFFFFF));
                1: mem[a+9]  = 24'($urandom_range(1, 24'hFFFFFF));
                2: mem[a+11] = 24'($urandom_range(1, 24'hFFFFFF));
                default: mem[a+10][23:1] = 23'($urandom_range(1, 23'h7FFFFF));
            endcase
        end
    endtask

    // Observed results of one operation.
    int          r_lat, r_nwb, r_nflt;
    bit          r_wb, r_flt, r_unstable, r_timeout, r_spur;
    logic [2:0]  r_code;
    logic [47:0] r_base, r_len, r_cur;
    logic [23:0] r_perms, r_attr;
    logic        r_tag;

    // Runs one load from an idle DUT; entered and left at posedge+1.
    task automatic do_op(input int rdy_dly, input bit noise);
        int cyc = 0, wcnt = 0;
        bit prev_vld = 0;
        logic [47:0] keep_cur = auth_cur;
        r_lat = 0; r_nwb = 0; r_nflt = 0; r_wb = 0; r_flt = 0; r_code = 0;
        r_unstable = 0; r_timeout = 1; r_spur = 0;
        n_req_cyc = 0; n_gnt = 0; proto_viol = 0; gnt_q.delete();
        start = 1'b1;
        while (cyc < 3000) begin
            @(posedge clk); #1; cyc++;
            start = 1'b0;
            if (wb_ready && prev_vld) r_nwb++;
            wb_ready = 1'b0;
            if (fault) begin
                r_nflt++;
                if (!r_flt) begin r_flt = 1; r_code = fault_code; r_lat = cyc; end
            end
            if (wb_valid) begin
                if (!r_wb) begin
                    r_wb = 1; r_lat = cyc;
                    r_base = cap_base; r_len = cap_len; r_cur = cap_cur;
                    r_perms = cap_perms; r_attr = cap_attr; r_tag = cap_tag;
                end else if ({r_base, r_len, r_cur, r_perms, r_attr, r_tag} !==
                             {cap_base, cap_len, cap_cur, cap_perms, cap_attr, cap_tag}) begin
                    r_unstable = 1;
                end
                if (wcnt >= rdy_dly) wb_ready = 1'b1;
                wcnt++;
            end
            prev_vld = wb_valid;
            if (!busy) begin r_timeout = 0; break; end
            if (noise) begin
                start    = 1'($urandom);
                auth_cur = {16'h0, 32'($urandom)};
            end
        end
        start = 1'b0; wb_ready = 1'b0; auth_cur = keep_cur;
        repeat (3) begin
            @(posedge clk); #1;
            if (wb_valid || fault || busy || mem_req) r_spur = 1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_cmp++;
        if ({busy, mem_req, wb_valid, fault, fault_code} !== 7'h0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 0", {busy, mem_req, wb_valid, fault, fault_code});
        end
        n_cmp++;
        if ({mem_addr, cap_base, cap_len, cap_cur, cap_perms, cap_attr, cap_tag} !== '0) begin
            n_err++; $display("FAIL reset_data: got base=%0h addr=%0h want 0", cap_base, mem_addr);
        end
    endtask

    task automatic test_load_basic();
        bit bad = 0;
        std_image(300, 24'h0);
        set_auth(200, 200, 300, 24'h000018, 1'b1, 0);
        stall_n = 0; rlat = 1;
        do_op(0, 0);
        n_cmp++;
        if (r_timeout || !r_wb || r_flt || r_nwb != 1 || r_spur) begin
            n_err++; $display("FAIL basic_outcome: got wb=%0d flt=%0d nwb=%0d to=%0d want 1/0/1/0", r_wb, r_flt, r_nwb, r_timeout);
        end
        n_cmp++;
        if ({r_base, r_len, r_cur, r_perms, r_attr, r_tag} !==
            {48'd1234, 48'd5678, 48'd91011, 24'h00ABCD, 24'h001122, 1'b1}) begin
            n_err++; $display("FAIL basic_fields: got %0d %0d %0d %h %h %0d want 1234 5678 91011 00abcd 001122 1",
                              r_base, r_len, r_cur, r_perms, r_attr, r_tag);
        end
        n_cmp++;
        if (r_lat != 26) begin
            n_err++; $display("FAIL basic_latency: got %0d want 26", r_lat);
        end
        for (int k = 0; k < 12; k++)
            if (k >= gnt_q.size() || gnt_q[k] !== 48'(300 + k)) bad = 1;
        n_cmp++;
        if (bad || gnt_q.size() != 12 || proto_viol != 0) begin
            n_err++; $display("FAIL basic_addr_seq: got %0d grants viol=%0d want 12 grants 300..311 viol=0", gnt_q.size(), proto_viol);
        end
    endtask

    task automatic test_malformed();
        std_image(300, 24'h000001);
        set_auth(200, 200, 300, 24'h000018, 1'b1, 0);
        do_op(1, 0);
        if (STRICT) begin
            n_cmp++;
            if (r_timeout || r_wb || !r_flt || r_code !== 3'd5 || r_nflt != 1) begin
                n_err++; $display("FAIL malf_strict: got wb=%0d flt=%0d code=%0d want wb=0 code=5", r_wb, r_flt, r_code);
            end
        end else begin
            n_cmp++;
            if (r_timeout || !r_wb || r_flt || r_tag !== 1'b0 || r_base !== 48'd1234) begin
                n_err++; $display("FAIL malf_tag: got wb=%0d flt=%0d tag=%0d base=%0d want 1/0/0/1234", r_wb, r_flt, r_tag, r_base);
            end
        end
        std_image(300, 24'h0);
    endtask

    task automatic test_faults();
        int b[5]  = '{200, 200, 200, 200, 200};
        int l[5]  = '{100, 200, 200, 200, 112};
        int c[5]  = '{290, 300, 300, 300, 300};
        int im[5] = '{0,   0,   0,   -200, 1};
        logic [23:0] p[5] = '{24'h18, 24'h18, 24'h10, 24'h18, 24'h18};
        logic t[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0] ex[5] = '{3'd4, 3'd1, 3'd2, 3'd3, 3'd4};
        for (int i = 0; i < 5; i++) begin
            set_auth(b[i], l[i], c[i], p[i], t[i], im[i]);
            do_op(0, 0);
            n_cmp++;
            if (r_timeout || !r_flt || r_code !== ex[i] || r_wb || r_nflt != 1 || n_req_cyc != 0 || r_lat != 2) begin
                n_err++; $display("FAIL fault_%0d: got code=%0d flt=%0d n=%0d req=%0d lat=%0d want code=%0d n=1 req=0 lat=2",
                                  i, r_code, r_flt, r_nflt, n_req_cyc, r_lat, ex[i]);
            end
        end
        // Access ending exactly at the limit is legal.
        set_auth(200, 112, 300, 24'h18, 1'b1, 0);
        do_op(0, 0);
        n_cmp++;
        if (r_timeout || !r_wb || r_flt || r_tag !== 1'b1) begin
            n_err++; $display("FAIL bound_exact: got wb=%0d flt=%0d code=%0d want wb=1 flt=0", r_wb, r_flt, r_code);
        end
    endtask

    task automatic test_lt_clear();
        set_auth(200, 200, 300, 24'h000008, 1'b1, 0);
        do_op(0, 0);
        n_cmp++;
        if (r_timeout || !r_wb || r_tag !== 1'b0 || r_cur !== 48'd91011 || r_attr !== 24'h001122) begin
            n_err++; $display("FAIL lt_clear: got wb=%0d tag=%0d cur=%0d attr=%h want 1/0/91011/001122", r_wb, r_tag, r_cur, r_attr);
        end
    endtask

    task automatic test_flush();
        int cyc = 0;
        bit done = 0, flushed = 0, saw_wb = 0, saw_flt = 0;
        set_auth(200, 200, 300, 24'h18, 1'b1, 0);
        rlat = 3; n_gnt = 0; proto_viol = 0;
        start = 1'b1;
        while (cyc < 500 && !done) begin
            @(posedge clk); #1; cyc++;
            start = 1'b0; flush = 1'b0;
            if (wb_valid) saw_wb = 1;
            if (fault) saw_flt = 1;
            if (flushed && !busy) done = 1;
            else if (!flushed && n_gnt == 6 && !mem_req) begin
                flush = 1'b1; flushed = 1;
            end
        end
        flush = 1'b0;
        repeat (5) begin @(posedge clk); #1; if (wb_valid || mem_req) saw_wb = 1; end
        n_cmp++;
        if (!done || saw_wb || saw_flt || n_gnt != 6 || pend || proto_viol != 0) begin
            n_err++; $display("FAIL flush_wait: got done=%0d wb=%0d flt=%0d grants=%0d pend=%0d want 1/0/0/6/0",
                              done, saw_wb, saw_flt, n_gnt, pend);
        end
        rlat = 1;
        do_op(0, 0);
        n_cmp++;
        if (r_timeout || !r_wb || r_tag !== 1'b1 || r_base !== 48'd1234 || r_perms !== 24'h00ABCD) begin
            n_err++; $display("FAIL flush_recover: got wb=%0d tag=%0d base=%0d want 1/1/1234", r_wb, r_tag, r_base);
        end
    endtask

    task automatic test_backpressure();
        set_auth(200, 200, 300, 24'h18, 1'b1, 0);
        stall_n = 3;
        do_op(4, 0);
        stall_n = 0;
        n_cmp++;
        if (r_timeout || r_nwb != 1 || r_unstable || proto_viol != 0 || r_spur || n_gnt != 12) begin
            n_err++; $display("FAIL backpressure: got nwb=%0d unstable=%0d viol=%0d grants=%0d want 1/0/0/12",
                              r_nwb, r_unstable, proto_viol, n_gnt);
        end
        n_cmp++;
        if ({r_base, r_len, r_cur, r_tag} !== {48'd1234, 48'd5678, 48'd91011, 1'b1}) begin
            n_err++; $display("FAIL backpressure_fields: got %0d %0d %0d %0d want 1234 5678 91011 1", r_base, r_len, r_cur, r_tag);
        end
    endtask

    task automatic test_reset_mid();
        set_auth(200, 200, 300, 24'h18, 1'b1, 0);
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        rst_n = 1'b0; #1;
        n_cmp++;
        if ({busy, mem_req, wb_valid, cap_base, cap_len} !== '0) begin
            n_err++; $display("FAIL reset_mid: got busy=%0d req=%0d base=%0h want 0", busy, mem_req, cap_base);
        end
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(0, 0);
        n_cmp++;
        if (r_timeout || !r_wb || r_nwb != 1 || r_base !== 48'd1234 || r_tag !== 1'b1) begin
            n_err++; $display("FAIL reset_recover: got wb=%0d nwb=%0d base=%0d want 1/1/1234", r_wb, r_nwb, r_base);
        end
    endtask

    task automatic test_random();
        logic [2:0] ec; logic [47:0] eb, el, ecur; logic [23:0] ep, ea; logic et;
        for (int n = 0; n < 40; n++) begin
            int b = $urandom_range(0, 300);
            int l = $urandom_range(12, 400);
            int e = b + $urandom_range(0, l - 12);
            int im = $urandom_range(0, 100) - 50;
            int mode = $urandom_range(0, 9);
            logic [23:0] p = 24'($urandom) | 24'h8;
            set_auth(b, l, e - im, p, 1'b1, im);
            if (mode == 0) auth_tag = 1'b0;
            if (mode == 1) auth_perms[3] = 1'b0;
            if (mode == 2) auth_cur = auth_cur - 48'(e - b + 1);
            if (mode == 3) auth_cur = auth_cur + 48'(b + l - e - 11);
            rand_image(e, $urandom_range(0, 3) == 0);
            stall_n = $urandom_range(0, 2);
            rlat = $urandom_range(1, 2);
            model(ec, eb, el, ecur, ep, ea, et);
            do_op($urandom_range(0, 3), 1'($urandom));
            n_cmp++;
            if (r_timeout || r_wb !== (ec == 3'd0) || r_flt !== (ec != 3'd0) || (ec != 0 && r_code !== ec) ||
                (ec == 0 && r_nwb != 1) || r_unstable || proto_viol != 0) begin
                n_err++; $display("FAIL rand_outcome[%0d]: got wb=%0d flt=%0d code=%0d to=%0d want code=%0d",
                                  n, r_wb, r_flt, r_code, r_timeout, ec);
            end
            if (ec == 3'd0) begin
                n_cmp++;
                if ({r_base, r_len, r_cur, r_perms, r_attr, r_tag} !== {eb, el, ecur, ep, ea, et}) begin
                    n_err++; $display("FAIL rand_fields[%0d]: got %h %h %h %h %h %0d want %h %h %h %h %h %0d",
                                      n, r_base, r_len, r_cur, r_perms, r_attr, r_tag, eb, el, ecur, ep, ea, et);
                end
            end
        end
        stall_n = 0; rlat = 1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_load_basic();
        test_malformed();
        test_faults();
        test_lt_clear();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
